// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master access arbiter in front of a single-cycle data memory.
// Master 0 is the core, master 1 a loader/debug port. One access per cycle,
// zero-latency combinational grant, bounded ownership under contention and a
// saturating contention counter.
module dm_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          dm_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          owner,
    output logic [CW-1:0] conflict_cnt
);
    // hold_cnt must represent 0..MAX_HOLD inclusive
    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic          owner_q;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] conflict_q;
    logic          both_req;
    logic          gnt0;
    logic          gnt1;

    assign both_req = m0_req & m1_req;

    // Grant: sole requester wins; under contention the owner keeps the memory
    // until it has used MAX_HOLD consecutive grants. Reset masks everything.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rset) begin
            if (both_req) begin
                if (hold_cnt < HOLD_MAX) begin
                    gnt0 = ~owner_q;
                    gnt1 = owner_q;
                end else begin
                    gnt0 = owner_q;
                    gnt1 = ~owner_q;
                end
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    // Memory port mux: drive zeros when nobody is granted
    always_comb begin
        dm_we    = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (gnt0) begin
            dm_we    = m0_we;
            mem_addr = m0_addr;
            mem_wd   = m0_wdata;
        end else if (gnt1) begin
            dm_we    = m1_we;
            mem_addr = m1_addr;
            mem_wd   = m1_wdata;
        end
    end

    // Ownership / hold tracking; an idle cycle clears the hold history
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            owner_q  <= 1'b0;
            hold_cnt <= '0;
        end else if (gnt0 | gnt1) begin
            if (gnt1 == owner_q) begin
                if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
            end else begin
                owner_q  <= gnt1;
                hold_cnt <= HW'(1);
            end
        end else begin
            hold_cnt <= '0;
        end
    end

    // Saturating count of cycles in which both masters requested
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            conflict_q <= '0;
        end else if (both_req && conflict_q != CNT_MAX) begin
            conflict_q <= conflict_q + CW'(1);
        end
    end

    assign m0_gnt       = gnt0;
    assign m1_gnt       = gnt1;
    assign m0_rdata     = mem_rd;
    assign m1_rdata     = mem_rd;
    assign owner        = owner_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: instance "dut" (MAX_HOLD=4, CW=16) with a memory model,
// instance "dut_b" (MAX_HOLD=1, CW=4) for alternation and counter saturation.
module tb_dm_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct packed { logic g0; logic g1; } gexp_t;

    logic          clk;
    logic          rset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          dm_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          owner;
    logic [15:0]   conflict_cnt;

    logic          b_m0_req, b_m1_req;
    logic          b_m0_gnt, b_m1_gnt;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata;
    logic          b_dm_we;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_wd;
    logic [DW-1:0] b_mem_rd;
    logic          b_owner;
    logic [3:0]    b_conflict_cnt;

    logic [DW-1:0] mem [256];

    int vectors;
    int miscompares;
    gexp_t         sb_q[$];
    logic [DW-1:0] rd_q[$];

    dm_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4), .CW(16)) dut (
        .clk(clk), .rset(rset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .dm_we(dm_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .owner(owner), .conflict_cnt(conflict_cnt)
    );

    dm_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(1), .CW(4)) dut_b (
        .clk(clk), .rset(rset),
        .m0_req(b_m0_req), .m0_we(1'b1), .m0_addr(8'h01), .m0_wdata(32'h1),
        .m0_gnt(b_m0_gnt), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(1'b0), .m1_addr(8'h02), .m1_wdata(32'h2),
        .m1_gnt(b_m1_gnt), .m1_rdata(b_m1_rdata),
        .dm_we(b_dm_we), .mem_addr(b_mem_addr), .mem_wd(b_mem_wd), .mem_rd(b_mem_rd),
        .owner(b_owner), .conflict_cnt(b_conflict_cnt)
    );

    assign b_mem_rd = 32'h0;
    assign mem_rd   = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data memory model: write on the rising edge
    always @(posedge clk) if (dm_we) mem[mem_addr] <= mem_wd;

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        b_m0_req = 0; b_m1_req = 0;
    endtask

    // leaves the bench on a falling edge with reset released
    task automatic do_reset();
        @(negedge clk);
        idle();
        rset = 0;
        @(negedge clk);
        rset = 1;
    endtask

    task automatic test_reset();
        rset = 0;
        idle();
        m0_req = 1; m1_req = 1; m0_we = 1; m0_addr = 8'h33; m0_wdata = 32'hCAFE0001;
        b_m0_req = 1; b_m1_req = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, dm_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_gnt: got m0_gnt=%b m1_gnt=%b dm_we=%b, want 0 0 0", m0_gnt, m1_gnt, dm_we);
        end
        vectors++;
        if (mem_addr !== 8'h00 || mem_wd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_port: got addr=%h wd=%h, want 00 00000000", mem_addr, mem_wd);
        end
        vectors++;
        if (owner !== 1'b0 || conflict_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: got owner=%b cnt=%0d, want 0 0", owner, conflict_cnt);
        end
        vectors++;
        if ({b_m0_gnt, b_m1_gnt, b_dm_we} !== 3'b000 || b_conflict_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_b: got gnt=%b%b we=%b cnt=%0d, want 00 0 0", b_m0_gnt, b_m1_gnt, b_dm_we, b_conflict_cnt);
        end
        idle();
        rset = 1;
        @(negedge clk);
        // a normal write to establish a known word
        m0_req = 1; m0_we = 1; m0_addr = 8'h20; m0_wdata = 32'hA5A5A5A5;
        #1;
        vectors++;
        if (m0_gnt !== 1'b1 || dm_we !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_write: got m0_gnt=%b dm_we=%b, want 1 1", m0_gnt, dm_we);
        end
        @(negedge clk);
        // overwrite attempt aborted by reset before the edge
        m0_wdata = 32'h11111111;
        #1;
        vectors++;
        if (dm_we !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre: got dm_we=%b, want 1", dm_we);
        end
        #1 rset = 0;
        #1;
        vectors++;
        if (dm_we !== 1'b0 || m0_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_drop: got dm_we=%b m0_gnt=%b, want 0 0", dm_we, m0_gnt);
        end
        @(negedge clk);
        idle();
        vectors++;
        if (mem[8'h20] !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL abort_mem: got %h, want a5a5a5a5", mem[8'h20]);
        end
        rset = 1;
        @(negedge clk);
    endtask

    task automatic test_single_master();
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 8'h10; m1_wdata = 32'hDEADBEEF;
        rd_q.push_back(32'hDEADBEEF);
        #1;
        vectors++;
        if ({m1_gnt, m0_gnt, dm_we} !== 3'b101 || mem_addr !== 8'h10 || mem_wd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_write: got gnt1=%b gnt0=%b we=%b addr=%h wd=%h", m1_gnt, m0_gnt, dm_we, mem_addr, mem_wd);
        end
        @(negedge clk);
        m1_we = 0;
        #1;
        vectors++;
        if ({m1_gnt, m0_gnt, dm_we} !== 3'b100 || m1_rdata !== rd_q.pop_front()) begin
            miscompares++;
            $display("FAIL single_read: got gnt1=%b gnt0=%b we=%b rdata=%h, want 1 0 0 deadbeef", m1_gnt, m0_gnt, dm_we, m1_rdata);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_contention();
        logic [9:0] seq;
        gexp_t e;
        seq = 10'b00_1111_0000;
        do_reset();
        for (int i = 0; i < 10; i++) sb_q.push_back('{g0: ~seq[i], g1: seq[i]});
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            e = sb_q.pop_front();
            vectors++;
            if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
                miscompares++;
                $display("FAIL contention c%0d: got gnt0/1=%b%b, want %b%b", i, m0_gnt, m1_gnt, e.g0, e.g1);
            end
            @(negedge clk);
        end
        idle();
        #1;
        vectors++;
        if (conflict_cnt !== 16'd10 || owner !== 1'b0) begin
            miscompares++;
            $display("FAIL contention_cnt: got cnt=%0d owner=%b, want 10 0", conflict_cnt, owner);
        end
        @(negedge clk);
    endtask

    task automatic test_hold_saturation();
        gexp_t e;
        do_reset();
        for (int i = 0; i < 6; i++) sb_q.push_back('{g0: 1'b1, g1: 1'b0});
        for (int i = 0; i < 5; i++) sb_q.push_back('{g0: (i == 4), g1: (i != 4)});
        for (int i = 0; i < 11; i++) begin
            m0_req = 1; m1_req = (i >= 6);
            #1;
            e = sb_q.pop_front();
            vectors++;
            if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
                miscompares++;
                $display("FAIL hold_sat c%0d: got gnt0/1=%b%b, want %b%b", i, m0_gnt, m1_gnt, e.g0, e.g1);
            end
            if (i == 7) begin
                vectors++;
                if (owner !== 1'b1) begin
                    miscompares++;
                    $display("FAIL hold_sat_owner: got %b, want 1", owner);
                end
            end
            @(negedge clk);
        end
        idle();
        #1;
        vectors++;
        if (conflict_cnt !== 16'd5) begin
            miscompares++;
            $display("FAIL hold_sat_cnt: got %0d, want 5", conflict_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_idle_gap();
        gexp_t e;
        do_reset();
        sb_q.push_back('{g0: 1'b0, g1: 1'b1});
        sb_q.push_back('{g0: 1'b0, g1: 1'b1});
        sb_q.push_back('{g0: 1'b0, g1: 1'b0});
        for (int i = 0; i < 5; i++) sb_q.push_back('{g0: (i == 4), g1: (i != 4)});
        for (int i = 0; i < 8; i++) begin
            m1_req = (i != 2); m0_req = (i >= 3);
            #1;
            e = sb_q.pop_front();
            vectors++;
            if ({m0_gnt, m1_gnt} !== {e.g0, e.g1}) begin
                miscompares++;
                $display("FAIL idle_gap c%0d: got gnt0/1=%b%b, want %b%b", i, m0_gnt, m1_gnt, e.g0, e.g1);
            end
            if (i == 2) begin
                vectors++;
                if (owner !== 1'b1) begin
                    miscompares++;
                    $display("FAIL idle_gap_owner: got %b, want 1", owner);
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_alternate_and_saturate();
        gexp_t e;
        do_reset();
        for (int i = 0; i < 20; i++) sb_q.push_back('{g0: ~i[0], g1: i[0]});
        b_m0_req = 1; b_m1_req = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            e = sb_q.pop_front();
            vectors++;
            if ({b_m0_gnt, b_m1_gnt} !== {e.g0, e.g1}) begin
                miscompares++;
                $display("FAIL alternate c%0d: got gnt0/1=%b%b, want %b%b", i, b_m0_gnt, b_m1_gnt, e.g0, e.g1);
            end
            if (i == 15) begin
                vectors++;
                if (b_conflict_cnt !== 4'd15) begin
                    miscompares++;
                    $display("FAIL cnt_reach: got %0d, want 15", b_conflict_cnt);
                end
            end
            @(negedge clk);
        end
        idle();
        #1;
        vectors++;
        if (b_conflict_cnt !== 4'd15 || b_owner !== 1'b1) begin
            miscompares++;
            $display("FAIL cnt_sat: got cnt=%0d owner=%b, want 15 1", b_conflict_cnt, b_owner);
        end
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rset = 0;
        idle();
        test_reset();
        test_single_master();
        test_contention();
        test_hold_saturation();
        test_idle_gap();
        test_alternate_and_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-master arbiter that shares the single-cycle data memory (combinational read, write on `clk` rising edge) between the RISC-V core (master 0) and a secondary requester such as a loader or debug port (master 1). It grants one access per cycle, holds ownership for up to MAX_HOLD consecutive cycles under contention, and counts contention cycles. It sits between the masters and the data memory's `dm_we`/`mem_addr`/`mem_wd`/`mem_rd` port. A master that is not granted stalls and holds its request stable.

## Interface
- AW, 8, address width (matches data memory `mem_addr`)
- DW, 32, data width
- MAX_HOLD, 4, max consecutive grants to one owner while the other requests (≥1)
- CW, 16, conflict counter width

- clk  in  1  clock, rising edge
- rset  in  1  reset, asynchronous, active-low
- m0_req  in  1  core access request
- m0_we  in  1  core write enable (valid with m0_req)
- m0_addr  in  AW  core word address
- m0_wdata  in  DW  core write data
- m0_gnt  out  1  core access performed this cycle
- m0_rdata  out  DW  read data to core (valid when m0_gnt & !m0_we)
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata  same as m0_*, master 1
- dm_we  out  1  data memory write enable
- mem_addr  out  AW  data memory address
- mem_wd  out  DW  data memory write data
- mem_rd  in  DW  data memory read data (combinational from mem_addr)
- owner  out  1  registered last owner (0 = core, 1 = master 1)
- conflict_cnt  out  CW  saturating count of cycles with both requests

## Operation
- State: `owner` (1 b), `hold_cnt` (0..MAX_HOLD), `conflict_cnt`.
- Grant (combinational from inputs and state):
  - no req: no grant
  - only mX_req: grant X
  - both: grant `owner` if hold_cnt < MAX_HOLD, else grant the other master
- Datapath: granted master's we/addr/wdata drive dm_we/mem_addr/mem_wd. With no grant: dm_we=0, mem_addr=0, mem_wd=0. mem_rd broadcast to m0_rdata and m1_rdata unconditionally; meaningful only when granted.
- Per-edge update:
  - grant to X with X == owner: hold_cnt ← min(hold_cnt+1, MAX_HOLD)
  - grant to X with X != owner: owner ← X, hold_cnt ← 1
  - no grant: hold_cnt ← 0, owner unchanged
  - both requests: conflict_cnt ← conflict_cnt+1, saturating at 2^CW−1
- Without contention a master may hold the memory indefinitely; hold_cnt saturates and forces a switch on the first contention cycle.
- Masters keep req/we/addr/wdata stable until gnt is seen; the arbiter does not queue.

## Timing
- Zero-latency grant: gnt, dm_we, mem_addr, mem_wd are combinational in the request cycle. Write commits at the same rising edge; read data is valid in the same cycle.
- State updates on the rising edge that ends the grant cycle.
- Reset (rset=0, async): owner=0, hold_cnt=0, conflict_cnt=0. While rset=0: m0_gnt=m1_gnt=0, dm_we=0, mem_addr=0, mem_wd=0 regardless of requests.
- Reset asserted mid-access: gnt and dm_we drop immediately; no write commits at the next edge. After release, the first contention grants master 0.
- Simultaneous requests out of reset: master 0 wins (owner=0, hold_cnt=0 < MAX_HOLD).
- MAX_HOLD=1: strict alternation under continuous contention.

## Test plan
- Reset: rset=0 with both reqs high, m0_we=1 -> all gnt=0, dm_we=0, mem_addr=0, owner=0, conflict_cnt=0. Assert rset during a granted write -> dm_we falls before the next edge and the memory word is unchanged.
- Single master: m1 writes 0xDEADBEEF at addr 0x10, then reads addr 0x10 -> m1_gnt=1 both cycles, m1_rdata=0xDEADBEEF, m0_gnt=0.
- Contention, MAX_HOLD=4: both reqs held high for 10 cycles from reset -> grant sequence 0,0,0,0,1,1,1,1,0,0; conflict_cnt=10.
- Hold saturation: m0 alone for 6 cycles, then both request -> m1 granted on the first contention cycle, owner=1, hold_cnt=1.
- Idle gap: m1 granted 2 cycles, one idle cycle, then both request -> m1 granted (owner=1, hold_cnt reset to 0).
- Counter saturation, CW=4: 20 contention cycles -> conflict_cnt stays at 15.
